// File: rtl/rr_decode_arbiter_pkg.sv
// Shared constants and types for the round-robin decode arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_decode_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_decode_arbiter_decoder2x4.sv
// 2-to-4 one-hot decoder with enable; y[x] set when en is high, all-zero otherwise.
// Latency: combinational.
// Backpressure: none.
// Ports: x - binary index, en - output enable, y - one-hot result (y[0] is index 0).
module decoder2x4
    import rr_decode_arbiter_pkg::*;
(
    input  logic [IDX_W-1:0]   x,
    input  logic               en,
    output logic [0:NUM_REQ-1] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[x] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter sharing one resource among 4 requesters, one-hot grant via decoder.
// Latency: 1 cycle req->gnt; at least one dead (idle) cycle between consecutive grants.
// Backpressure: none; a grant is held while req stays high, up to MAX_HOLD cycles when enabled.
// Ports: clk, rst (sync, active-high); req[0:3] level requests;
//        gnt[0:3] one-hot grant; gnt_idx last winner; gnt_valid live grant;
//        preempt one-cycle pulse when the hold limit ended a grant.
module rr_decode_arbiter
    import rr_decode_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [0:NUM_REQ-1] req,
    output logic [0:NUM_REQ-1] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               preempt
);

    localparam bit               PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_SAT   = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [IDX_W-1:0] pick;
    logic             hold_expired;

    // First set request scanning ptr, ptr+1, ... modulo 4.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [0:NUM_REQ-1] r,
        input logic [IDX_W-1:0]   p
    );
        logic [IDX_W-1:0] idx;
        logic             found;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = p + IDX_W'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign pick         = rr_pick(req, ptr);
    assign hold_expired = PREEMPT_EN && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt_idx   <= pick;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= ST_GRANT;
                    end else begin
                        gnt_valid <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // A voluntary drop takes precedence over the hold limit,
                    // so preempt only fires when the owner still wants the slot.
                    if (!req[gnt_idx] || hold_expired) begin
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + 1'b1;
                        state     <= ST_IDLE;
                        preempt   <= req[gnt_idx];
                    end
                    if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    decoder2x4 u_dec (
        .x  (gnt_idx),
        .en (gnt_valid),
        .y  (gnt)
    );

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed self-checking bench for rr_decode_arbiter (MAX_HOLD=8).
// Inputs change #1 after the rising edge; outputs are checked at the same point.
module tb_rr_decode_arbiter;

    logic       clk;
    logic       rst;
    logic [0:3] req;
    logic [0:3] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    rr_decode_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] onehot;

        // Reset held two cycles with every request asserted.
        rst = 1'b1;
        req = 4'b1111;
        tick();
        tick();
        chk("rst_gnt",     gnt,              4'b0000);
        chk("rst_valid",   {3'b0, gnt_valid}, 4'd0);
        chk("rst_preempt", {3'b0, preempt},   4'd0);
        chk("rst_idx",     {2'b0, gnt_idx},   4'd0);
        rst = 1'b0;
        tick();
        chk("first_gnt",   gnt,              4'b1000);
        chk("first_valid", {3'b0, gnt_valid}, 4'd1);
        req = 4'b0000;
        tick();
        chk("first_rel", gnt, 4'b0000);

        // Single requester 2 (ptr now 1).
        req = 4'b0010;
        tick();
        chk("single_gnt", gnt,             4'b0010);
        chk("single_idx", {2'b0, gnt_idx}, 4'd2);
        req = 4'b0000;
        tick();
        chk("single_rel",      gnt,              4'b0000);
        chk("single_rel_vld",  {3'b0, gnt_valid}, 4'd0);
        chk("idle_keeps_idx",  {2'b0, gnt_idx},   4'd2);
        // ptr is 3: with 0 and 3 requesting, 3 wins.
        req = 4'b1001;
        tick();
        chk("next_pref3_gnt", gnt,             4'b0001);
        chk("next_pref3_idx", {2'b0, gnt_idx}, 4'd3);

        // Mid-grant reset.
        rst = 1'b1;
        tick();
        chk("midrst_gnt",   gnt,              4'b0000);
        chk("midrst_idx",   {2'b0, gnt_idx},  4'd0);
        chk("midrst_valid", {3'b0, gnt_valid}, 4'd0);
        rst = 1'b0;
        tick();
        chk("midrst_ptr0_gnt", gnt, 4'b1000);
        req = 4'b0000;
        tick();
        chk("midrst_rel", gnt, 4'b0000);

        // Rotation from a clean reset: order 0,1,2,3,0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            onehot = 4'b1000 >> (k % 4);
            req = 4'b1111;
            tick();
            chk("rot_gnt_c1", gnt,             onehot);
            chk("rot_idx",    {2'b0, gnt_idx}, 4'(k % 4));
            tick();
            chk("rot_gnt_c2", gnt, onehot);
            req = 4'b1111 & ~onehot;
            tick();
            chk("rot_idle", gnt, 4'b0000);
        end

        // Preemption: requester 0 alone, held forever.
        req = 4'b1000;
        tick();
        for (int c = 0; c < 8; c++) begin
            chk("pre_hold_gnt", gnt,             4'b1000);
            chk("pre_hold_pe",  {3'b0, preempt}, 4'd0);
            tick();
        end
        chk("pre_cut_gnt",   gnt,             4'b0000);
        chk("pre_cut_pulse", {3'b0, preempt}, 4'd1);
        tick();
        chk("pre_regrant",   gnt,             4'b1000);
        chk("pre_pulse_end", {3'b0, preempt}, 4'd0);

        // Simultaneous: drop on the cycle the hold limit would trip.
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("sim_hold_gnt", gnt, 4'b1000);
        end
        req = 4'b0000;
        tick();
        chk("sim_rel_gnt", gnt,             4'b0000);
        chk("sim_rel_pe",  {3'b0, preempt}, 4'd0);
        tick();
        chk("sim_after_pe", {3'b0, preempt}, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
